// File: rtl/gerenciador_atributos.sv
// Pet attribute manager: owns fome/felicidade/sono, decays them on a slow
// time base and replenishes the attribute served by the current estado.
module gerenciador_atributos #(
   parameter int unsigned TICK_CYCLES = 4_000_000,
   parameter logic [7:0]  INIT_VAL    = 8'd200,
   parameter int unsigned FOME_PER    = 3,
   parameter int unsigned FELIC_PER   = 5,
   parameter int unsigned SONO_PER    = 4,
   parameter logic [7:0]  DECAY       = 8'd1,
   parameter logic [7:0]  GAIN        = 8'd6,
   parameter logic [7:0]  LOW_THRESH  = 8'd32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] estado,
   output logic [7:0] fome,
   output logic [7:0] felicidade,
   output logic [7:0] sono,
   output logic       tick,
   output logic       alerta
);

   localparam logic [4:0] INTRO      = 5'b00000;
   localparam logic [4:0] IDLE       = 5'b00001;
   localparam logic [4:0] DORMINDO   = 5'b00010;
   localparam logic [4:0] COMENDO    = 5'b00100;
   localparam logic [4:0] DANDO_AULA = 5'b01000;
   localparam logic [4:0] MORTO      = 5'b10000;

   localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [15:0]   FOME_LAST  = 16'(FOME_PER - 1);
   localparam logic [15:0]   FELIC_LAST = 16'(FELIC_PER - 1);
   localparam logic [15:0]   SONO_LAST  = 16'(SONO_PER - 1);

   logic [PW-1:0] presc_q;
   logic [15:0]   cnt_fome_q, cnt_fome_d;
   logic [15:0]   cnt_felic_q, cnt_felic_d;
   logic [15:0]   cnt_sono_q, cnt_sono_d;
   logic [7:0]    fome_q, fome_d;
   logic [7:0]    felic_q, felic_d;
   logic [7:0]    sono_q, sono_d;
   logic          tick_q;
   logic          alerta_q, alerta_d;
   logic          wrap;
   logic          ativo;
   logic          ev_fome, ev_felic, ev_sono;

   // Gain wins over decay; decay floors at 0, gain saturates at 255.
   function automatic logic [7:0] atualiza(input logic [7:0] v, input logic ganho,
                                           input logic decai, input logic duplo);
      logic [8:0] soma;
      logic [8:0] amt;
      soma = {1'b0, v} + {1'b0, GAIN};
      amt  = duplo ? {DECAY, 1'b0} : {1'b0, DECAY};
      if (ganho) begin
         atualiza = soma[8] ? 8'hff : soma[7:0];
      end else if (decai) begin
         atualiza = ({1'b0, v} < amt) ? 8'h00 : 8'(({1'b0, v} - amt));
      end else begin
         atualiza = v;
      end
   endfunction

   assign wrap  = (presc_q == PRESC_LAST);
   assign ativo = (estado == IDLE) || (estado == DORMINDO) ||
                  (estado == COMENDO) || (estado == DANDO_AULA);
   assign ev_fome  = (cnt_fome_q == FOME_LAST);
   assign ev_felic = (cnt_felic_q == FELIC_LAST);
   assign ev_sono  = (cnt_sono_q == SONO_LAST);

   // Next-state for attributes and decay counters, only changing on tick edges.
   always_comb begin
      fome_d      = fome_q;
      felic_d     = felic_q;
      sono_d      = sono_q;
      cnt_fome_d  = cnt_fome_q;
      cnt_felic_d = cnt_felic_q;
      cnt_sono_d  = cnt_sono_q;
      if (wrap) begin
         if (estado == INTRO) begin
            fome_d      = INIT_VAL;
            felic_d     = INIT_VAL;
            sono_d      = INIT_VAL;
            cnt_fome_d  = '0;
            cnt_felic_d = '0;
            cnt_sono_d  = '0;
         end else if (ativo) begin
            cnt_fome_d  = ev_fome  ? '0 : cnt_fome_q + 16'd1;
            cnt_felic_d = ev_felic ? '0 : cnt_felic_q + 16'd1;
            cnt_sono_d  = ev_sono  ? '0 : cnt_sono_q + 16'd1;
            fome_d  = atualiza(fome_q, estado == COMENDO, ev_fome, estado == DANDO_AULA);
            felic_d = atualiza(felic_q, estado == DANDO_AULA, ev_felic, 1'b0);
            sono_d  = atualiza(sono_q, estado == DORMINDO, ev_sono, estado == DANDO_AULA);
         end
      end
   end

   // Low-attribute flag, evaluated every clock from the current outputs.
   always_comb begin
      alerta_d = ((fome_q < LOW_THRESH) || (felic_q < LOW_THRESH) || (sono_q < LOW_THRESH)) &&
                 (estado != MORTO);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         cnt_fome_q  <= '0;
         cnt_felic_q <= '0;
         cnt_sono_q  <= '0;
         fome_q      <= INIT_VAL;
         felic_q     <= INIT_VAL;
         sono_q      <= INIT_VAL;
         tick_q      <= 1'b0;
         alerta_q    <= 1'b0;
      end else begin
         presc_q     <= wrap ? '0 : presc_q + PW'(1);
         cnt_fome_q  <= cnt_fome_d;
         cnt_felic_q <= cnt_felic_d;
         cnt_sono_q  <= cnt_sono_d;
         fome_q      <= fome_d;
         felic_q     <= felic_d;
         sono_q      <= sono_d;
         tick_q      <= wrap;
         alerta_q    <= alerta_d;
      end
   end

   assign fome       = fome_q;
   assign felicidade = felic_q;
   assign sono       = sono_q;
   assign tick       = tick_q;
   assign alerta     = alerta_q;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Bench for gerenciador_atributos: directed scenarios plus randomized estado
// traffic, checked every clock against an integer reference model.
module tb_gerenciador_atributos;

   localparam int TC    = 4;
   localparam int INIT  = 200;
   localparam int GAINV = 8;
   localparam int THR   = 32;

   logic       clk;
   logic       rst;
   logic [4:0] estado;
   logic [7:0] fome, felicidade, sono;
   logic       tick, alerta;

   int tests;
   int fails;

   // Reference model state: index 0 fome, 1 felicidade, 2 sono.
   int m_val[3];
   int m_cnt[3];
   int per[3];
   int m_presc;
   int m_tick;
   int m_alerta;
   int saved[3];

   gerenciador_atributos #(
      .TICK_CYCLES(TC),
      .INIT_VAL   (8'd200),
      .FOME_PER   (1),
      .FELIC_PER  (2),
      .SONO_PER   (3),
      .DECAY      (8'd1),
      .GAIN       (8'd8),
      .LOW_THRESH (8'd32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .estado    (estado),
      .fome      (fome),
      .felicidade(felicidade),
      .sono      (sono),
      .tick      (tick),
      .alerta    (alerta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock from the rules, given sampled rst/estado.
   task automatic model_edge(input logic r, input int est);
      int lowest;
      int gi;
      if (r) begin
         for (int i = 0; i < 3; i++) begin
            m_val[i] = INIT;
            m_cnt[i] = 0;
         end
         m_presc = 0; m_tick = 0; m_alerta = 0;
         return;
      end
      lowest = m_val[0];
      for (int i = 1; i < 3; i++) if (m_val[i] < lowest) lowest = m_val[i];
      m_alerta = (lowest < THR && est != 16) ? 1 : 0;
      m_tick = (m_presc == TC - 1) ? 1 : 0;
      m_presc = (m_presc + 1) % TC;
      if (m_tick == 1) begin
         if (est == 0) begin
            for (int i = 0; i < 3; i++) begin
               m_val[i] = INIT;
               m_cnt[i] = 0;
            end
         end else if (est == 1 || est == 2 || est == 4 || est == 8) begin
            gi = (est == 4) ? 0 : (est == 8) ? 1 : (est == 2) ? 2 : -1;
            for (int i = 0; i < 3; i++) begin
               bit ev;
               ev = (m_cnt[i] == per[i] - 1);
               m_cnt[i] = (m_cnt[i] + 1) % per[i];
               if (i == gi) m_val[i] = (m_val[i] + GAINV > 255) ? 255 : m_val[i] + GAINV;
               else if (ev) begin
                  m_val[i] = m_val[i] - ((est == 8) ? 2 : 1);
                  if (m_val[i] < 0) m_val[i] = 0;
               end
            end
         end
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_edge(rst, int'(estado));
      #1;
      chk("fome", int'(fome), m_val[0]);
      chk("felicidade", int'(felicidade), m_val[1]);
      chk("sono", int'(sono), m_val[2]);
      chk("tick", int'(tick), m_tick);
      chk("alerta", int'(alerta), m_alerta);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step_clk();
   endtask

   initial begin
      logic [4:0] pool [8];
      tests = 0; fails = 0;
      per[0] = 1; per[1] = 2; per[2] = 3;
      for (int i = 0; i < 3; i++) begin
         m_val[i] = 0; m_cnt[i] = 0;
      end
      m_presc = 0; m_tick = 0; m_alerta = 0;
      pool[0] = 5'b00000; pool[1] = 5'b00001; pool[2] = 5'b00010; pool[3] = 5'b00100;
      pool[4] = 5'b01000; pool[5] = 5'b10000; pool[6] = 5'b10101; pool[7] = 5'b00011;

      // 1: reset then IDLE decay
      rst = 1'b1; estado = 5'b00001;
      step_clk();
      chk("reset_fome", int'(fome), 200);
      chk("reset_tick", int'(tick), 0);
      chk("reset_alerta", int'(alerta), 0);
      rst = 1'b0;
      run(24);
      chk("idle_fome", int'(fome), 194);
      chk("idle_felic", int'(felicidade), 197);
      chk("idle_sono", int'(sono), 198);
      chk("idle_tick", int'(tick), 1);

      // 2: COMENDO saturation
      estado = 5'b00100;
      run(7 * TC);
      chk("comendo_250", int'(fome), 250);
      run(TC);
      chk("comendo_sat1", int'(fome), 255);
      run(TC);
      chk("comendo_sat2", int'(fome), 255);

      // 3: DANDO_AULA double decay with floor
      estado = 5'b01000;
      run(127 * TC);
      chk("aula_fome_1", int'(fome), 1);
      run(TC);
      chk("aula_floor", int'(fome), 0);
      chk("aula_felic_sat", int'(felicidade), 255);
      run(TC);
      chk("aula_floor_hold", int'(fome), 0);
      chk("aula_alerta", int'(alerta), 1);

      // 4: MORTO freeze, then INTRO reload and counter clear
      estado = 5'b10000;
      for (int i = 0; i < 3; i++) saved[i] = m_val[i];
      run(10 * TC);
      chk("morto_fome", int'(fome), saved[0]);
      chk("morto_felic", int'(felicidade), saved[1]);
      chk("morto_sono", int'(sono), saved[2]);
      chk("morto_alerta", int'(alerta), 0);
      estado = 5'b00000;
      run(TC);
      chk("intro_fome", int'(fome), 200);
      chk("intro_sono", int'(sono), 200);
      estado = 5'b00001;
      run(TC);
      chk("restart_fome", int'(fome), 199);
      chk("restart_felic", int'(felicidade), 200);
      chk("restart_sono", int'(sono), 200);

      // 5: reset in mid-tick
      for (int i = 0; i < TC && m_presc != 2; i++) step_clk();
      chk("presc_at_2", m_presc, 2);
      rst = 1'b1;
      step_clk();
      rst = 1'b0;
      chk("midrst_fome", int'(fome), 200);
      chk("midrst_tick", int'(tick), 0);
      run(3);
      chk("midrst_no_tick", int'(tick), 0);
      run(1);
      chk("midrst_first_tick", int'(tick), 1);

      // 6: illegal code freezes
      estado = 5'b10101;
      for (int i = 0; i < 3; i++) saved[i] = m_val[i];
      run(3 * TC);
      chk("illegal_fome", int'(fome), saved[0]);
      chk("illegal_felic", int'(felicidade), saved[1]);
      chk("illegal_sono", int'(sono), saved[2]);

      // Randomized traffic, including illegal codes and occasional resets
      for (int k = 0; k < 300; k++) begin
         estado = pool[$urandom_range(0, 7)];
         rst = ($urandom_range(0, 39) == 0);
         step_clk();
         rst = 1'b0;
         run($urandom_range(1, 12));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
